if_unit: RTL and testbench

Instruction-fetch stage of the SimpleRisc pipeline. It owns the PC, issues word reads to instruction memory over a split request/response interface, and drives the IF/OF pipeline register. That register is the `instruction_in` / `pc_in` pair consumed by the operand-fetch stage. The block also absorbs OF-side stalls with a one-entry holding buffer, and redirects/flushes on taken branches from EX.

---
 rtl/if_unit.sv | 145 ++++++++++++++
 tb/tb_if_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_unit.sv
// Instruction-fetch stage of the SimpleRisc pipeline.
//
// Owns the PC and issues single-word reads to instruction memory over a split
// request/response interface, with at most one read outstanding. Fetched words
// go into the IF/OF register (pc_out / instruction_out / valid_out). If OF is
// stalled when a response returns, the word waits in a one-entry buffer. A taken
// branch from EX redirects the PC and flushes the register and the buffer. A
// response that is still in flight at the time of the branch is dropped.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   stall            OF cannot accept; IF/OF register holds
//   is_branch_taken  EX redirect this cycle (overrides stall)
//   branch_pc        redirect target
//   imem_req         read request (combinational from state)
//   imem_addr        read address (internal PC)
//   imem_rvalid      read response valid (in order, one outstanding max)
//   imem_rdata       instruction word returned with imem_rvalid
//   pc_out           PC of the instruction in the IF/OF register
//   instruction_out  instruction in the IF/OF register (NOP_INSTR when invalid)
//   valid_out        IF/OF register holds a real instruction
module if_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h6800_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_branch_taken,
  input  logic [31:0] branch_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  logic [31:0] pc_q, pc_d;
  logic        outstanding_q, outstanding_d;
  logic        discard_q, discard_d;
  logic [31:0] issue_pc_q, issue_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic        valid_out_q, valid_out_d;

  logic free;
  logic issue;

  always_comb begin
    // The IF/OF register can take a new word if it is empty or OF is consuming it.
    free = !valid_out_q || !stall;
    // A new request may go out in the same cycle the previous response returns.
    issue = reset && !is_branch_taken && !buf_valid_q && free &&
            (!outstanding_q || imem_rvalid);

    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    issue_pc_d    = issue_pc_q;
    buf_valid_d   = buf_valid_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    pc_out_d      = pc_out_q;
    instr_out_d   = instr_out_q;
    valid_out_d   = valid_out_q;

    if (issue) begin
      issue_pc_d    = pc_q;
      pc_d          = pc_q + 32'd4;
      outstanding_d = 1'b1;
    end else if (imem_rvalid) begin
      outstanding_d = 1'b0;
    end

    if (is_branch_taken) begin
      pc_d        = branch_pc;
      valid_out_d = 1'b0;
      instr_out_d = NOP_INSTR;
      buf_valid_d = 1'b0;
      // A read still in flight belongs to the old path; remember to drop it.
      discard_d   = outstanding_q && !imem_rvalid;
    end else begin
      if (imem_rvalid && discard_q) begin
        discard_d = 1'b0;
      end
      if (imem_rvalid && !discard_q && free) begin
        pc_out_d    = issue_pc_q;
        instr_out_d = imem_rdata;
        valid_out_d = 1'b1;
      end else if (imem_rvalid && !discard_q) begin
        buf_pc_d    = issue_pc_q;
        buf_instr_d = imem_rdata;
        buf_valid_d = 1'b1;
      end else if (buf_valid_q && !stall) begin
        // No response can coincide: nothing is outstanding while the buffer is full.
        pc_out_d    = buf_pc_q;
        instr_out_d = buf_instr_q;
        valid_out_d = 1'b1;
        buf_valid_d = 1'b0;
      end else if (!stall) begin
        valid_out_d = 1'b0;
        instr_out_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      issue_pc_q    <= 32'h0;
      buf_valid_q   <= 1'b0;
      buf_pc_q      <= 32'h0;
      buf_instr_q   <= 32'h0;
      pc_out_q      <= 32'h0;
      instr_out_q   <= NOP_INSTR;
      valid_out_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      issue_pc_q    <= issue_pc_d;
      buf_valid_q   <= buf_valid_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
      pc_out_q      <= pc_out_d;
      instr_out_q   <= instr_out_d;
      valid_out_q   <= valid_out_d;
    end
  end

  assign imem_req        = issue;
  assign imem_addr       = pc_q;
  assign pc_out          = pc_out_q;
  assign instruction_out = instr_out_q;
  assign valid_out       = valid_out_q;

endmodule

// File: tb/tb_if_unit.sv
module tb_if_unit;

  localparam logic [31:0] Nop = 32'h6800_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        is_branch_taken;
  logic [31:0] branch_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  always #5 clk = ~clk;

  if_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .is_branch_taken (is_branch_taken),
    .branch_pc       (branch_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = 32'h1000_0000 | pc;
    sb_q.push_back(e);
  endtask

  // Memory model: fixed latency mem_lat, rdata = 0x1000_0000 | addr.
  initial forever begin
    @(negedge clk);
    if (reset === 1'b1 && imem_req === 1'b1) begin
      mem_cnt  = mem_lat;
      mem_addr = imem_addr;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (reset !== 1'b1 || mem_cnt == 0) begin
      mem_cnt     = 0;
      imem_rvalid = 1'b0;
    end else begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1000_0000 | mem_addr;
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge reset);
    mem_cnt     = 0;
    imem_rvalid = 1'b0;
  end

  // Monitor: every instruction accepted by OF is checked against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && valid_out === 1'b1 && stall === 1'b0) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got pc 0x%08h, want no output", pc_out);
        end else begin
          e = sb_q.pop_front();
          chk("out_pc", pc_out, e.pc);
          chk("out_instr", instruction_out, e.instr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  task automatic start(input int lat);
    reset           = 1'b0;
    stall           = 1'b0;
    is_branch_taken = 1'b0;
    branch_pc       = 32'h0;
    mem_lat         = lat;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic finish_scn(input string name);
    reset = 1'b0;
    #1;
    chk(name, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles 1..8 with L = 2: outputs pc 0 (c4), pc 4 (c6), stall from c6, 0x8 buffered in c7.
  task automatic stall_prefix();
    for (int c = 1; c <= 8; c++) begin
      stall = (c >= 6);
      @(negedge clk);
      if (c == 5) begin
        chk("stl_req5", 32'(imem_req), 32'd1);
        chk("stl_addr5", imem_addr, 32'h8);
      end
      if (c >= 6) begin
        chk("stl_req_frozen", 32'(imem_req), 32'd0);
        chk("stl_pc_frozen", pc_out, 32'h4);
        chk("stl_instr_frozen", instruction_out, 32'h1000_0004);
        chk("stl_valid_frozen", 32'(valid_out), 32'd1);
      end
      step();
    end
  endtask

  initial begin
    reset           = 1'b0;
    stall           = 1'b0;
    is_branch_taken = 1'b0;
    branch_pc       = 32'h0;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'h0;

    // Reset values while reset is held.
    @(negedge clk);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr", instruction_out, Nop);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);

    // L = 1: one instruction per cycle, then an asynchronous reset mid-fetch.
    start(1);
    push(32'h0); push(32'h4); push(32'h8);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("l1_req", 32'(imem_req), 32'd1);
      chk("l1_addr", imem_addr, 32'(4 * (c - 1)));
      chk("l1_valid", 32'(valid_out), (c >= 3) ? 32'd1 : 32'd0);
      step();
    end
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(valid_out), 32'd0);
    chk("async_pc_out", pc_out, 32'h0);
    chk("async_instr", instruction_out, Nop);
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_addr", imem_addr, 32'h0);
    finish_scn("l1_leftover");

    // L = 3: requests at 1, 4, 7; valid pulses at 5, 8.
    start(3);
    push(32'h0); push(32'h4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("l3_req", 32'(imem_req), (c == 1 || c == 4 || c == 7) ? 32'd1 : 32'd0);
      if (c == 1) chk("l3_addr1", imem_addr, 32'h0);
      if (c == 4) chk("l3_addr4", imem_addr, 32'h4);
      if (c == 7) chk("l3_addr7", imem_addr, 32'h8);
      chk("l3_valid", 32'(valid_out), (c == 5 || c == 8) ? 32'd1 : 32'd0);
      if (c == 6 || c == 7) chk("l3_nop", instruction_out, Nop);
      step();
    end
    finish_scn("l3_leftover");

    // L = 2: stall with 0x4 valid, 0x8 lands in the buffer, then release.
    start(2);
    push(32'h0); push(32'h4); push(32'h8);
    stall_prefix();
    stall = 1'b0;
    @(negedge clk);
    chk("rel_req9", 32'(imem_req), 32'd0);
    step();
    @(negedge clk);
    chk("rel_req10", 32'(imem_req), 32'd1);
    chk("rel_addr10", imem_addr, 32'hC);
    step();
    @(negedge clk);
    chk("rel_valid11", 32'(valid_out), 32'd0);
    step();
    finish_scn("stall_leftover");

    // L = 3: branch to 0x40 one cycle after the request for 0x8.
    start(3);
    push(32'h0); push(32'h4); push(32'h40);
    for (int c = 1; c <= 14; c++) begin
      is_branch_taken = (c == 8);
      branch_pc       = 32'h40;
      @(negedge clk);
      if (c == 7) begin
        chk("br_req7", 32'(imem_req), 32'd1);
        chk("br_addr7", imem_addr, 32'h8);
      end
      if (c == 8) chk("br_req8", 32'(imem_req), 32'd0);
      if (c == 9) chk("br_valid9", 32'(valid_out), 32'd0);
      if (c == 10) begin
        chk("br_req10", 32'(imem_req), 32'd1);
        chk("br_addr10", imem_addr, 32'h40);
      end
      if (c == 11 || c == 12) begin
        chk("br_req_idle", 32'(imem_req), 32'd0);
        chk("br_drop_valid", 32'(valid_out), 32'd0);
      end
      if (c == 13) chk("br_valid13", 32'(valid_out), 32'd0);
      if (c == 14) chk("br_valid14", 32'(valid_out), 32'd1);
      step();
    end
    finish_scn("br_leftover");

    // L = 2: branch while stalled with the buffer full.
    start(2);
    push(32'h0); push(32'h80);
    stall_prefix();
    stall           = 1'b1;
    is_branch_taken = 1'b1;
    branch_pc       = 32'h80;
    @(negedge clk);
    chk("bs_req9", 32'(imem_req), 32'd0);
    step();
    is_branch_taken = 1'b0;
    @(negedge clk);
    chk("bs_valid10", 32'(valid_out), 32'd0);
    chk("bs_instr10", instruction_out, Nop);
    chk("bs_req10", 32'(imem_req), 32'd1);
    chk("bs_addr10", imem_addr, 32'h80);
    step();
    stall = 1'b0;
    @(negedge clk);
    chk("bs_req11", 32'(imem_req), 32'd0);
    step();
    @(negedge clk);
    chk("bs_req12", 32'(imem_req), 32'd1);
    chk("bs_addr12", imem_addr, 32'h84);
    step();
    @(negedge clk);
    chk("bs_valid13", 32'(valid_out), 32'd1);
    step();
    finish_scn("bs_leftover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
